// File: rtl/flag_branch_if.sv
// EX/ID-side signal bundle for the flag register and branch resolver.
// The master drives the pipeline inputs; the slave (the unit) drives the results.
interface flag_branch_if #(
    parameter int CNT_W = 16
);
    logic             ex_valid;
    logic             ex_stall;
    logic [2:0]       ex_opcode;
    logic             ex_flags_set;
    logic [2:0]       ex_flags;
    logic             id_branch;
    logic [2:0]       id_cond;
    logic [2:0]       flags_q;
    logic             branch_taken;
    logic             branch_stall;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output ex_valid, ex_stall, ex_opcode, ex_flags_set, ex_flags, id_branch, id_cond,
        input  flags_q, branch_taken, branch_stall, stall_count
    );

    modport slave (
        input  ex_valid, ex_stall, ex_opcode, ex_flags_set, ex_flags, id_branch, id_cond,
        output flags_q, branch_taken, branch_stall, stall_count
    );
endinterface

// File: rtl/flag_branch_unit.sv
// Architectural {Z,V,N} flag register plus ID-stage branch condition resolver,
// with a one-cycle flag-hazard stall (or flag forwarding when BYPASS=1).
module flag_branch_unit #(
    parameter bit BYPASS = 1'b0,
    parameter int CNT_W  = 16
) (
    input logic          clk,
    input logic          rst,
    flag_branch_if.slave bus
);
    typedef enum logic {IDLE, WAIT} state_e;

    state_e           state_q, state_d;
    logic [2:0]       flags_q, flags_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       mask;
    logic [2:0]       f;
    logic             we, hz, cond_true, stall;

    always_comb begin
        unique case (bus.ex_opcode)
            3'b000, 3'b001:                 mask = 3'b111;
            3'b010, 3'b100, 3'b101, 3'b110: mask = 3'b100;
            default:                        mask = 3'b000;
        endcase
    end

    assign we      = bus.ex_valid & bus.ex_flags_set & ~bus.ex_stall;
    assign flags_d = we ? ((bus.ex_flags & mask) | (flags_q & ~mask)) : flags_q;
    assign hz      = bus.id_branch & bus.ex_valid & bus.ex_flags_set;
    // Forwarding evaluates against the flags EX is about to retire.
    assign f       = BYPASS ? flags_d : flags_q;

    always_comb begin
        unique case (bus.id_cond)
            3'b000:  cond_true = ~f[2];
            3'b001:  cond_true = f[2];
            3'b010:  cond_true = ~f[2] & ~f[0];
            3'b011:  cond_true = f[0];
            3'b100:  cond_true = f[2] | (~f[2] & ~f[0]);
            3'b101:  cond_true = f[0] | f[2];
            3'b110:  cond_true = f[1];
            default: cond_true = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        if (!BYPASS) begin
            unique case (state_q)
                IDLE: begin
                    stall = hz;
                    if (hz) state_d = WAIT;
                end
                WAIT: begin
                    // A branch that leaves ID (flush) releases the stall at once.
                    if (!bus.id_branch) begin
                        state_d = IDLE;
                    end else begin
                        stall = bus.ex_stall | hz;
                        if (!stall) state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= 3'b000;
            cnt_q   <= '0;
            state_q <= IDLE;
        end else begin
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign bus.flags_q      = flags_q;
    assign bus.branch_stall = stall;
    assign bus.branch_taken = bus.id_branch & ~stall & cond_true;
    assign bus.stall_count  = cnt_q;
endmodule

// File: tb/tb_flag_branch_unit.sv
// Scoreboard bench: DUT0 uses BYPASS=0, DUT1 uses BYPASS=1, both see identical stimulus.
module tb_flag_branch_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    flag_branch_if #(.CNT_W(16)) fb0 ();
    flag_branch_if #(.CNT_W(16)) fb1 ();

    flag_branch_unit #(.BYPASS(1'b0), .CNT_W(16)) dut0 (.clk(clk), .rst(rst), .bus(fb0));
    flag_branch_unit #(.BYPASS(1'b1), .CNT_W(16)) dut1 (.clk(clk), .rst(rst), .bus(fb1));

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, XOR = 3'b010, PADDSB = 3'b111;

    // -1 in a field means "do not check"
    typedef struct {
        string nm;
        int    sel;
        int    flg;
        int    tk;
        int    st;
        int    cnt;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, want);
        end
    endtask

    // Monitor: outputs are combinational, sampled mid-cycle on the falling edge.
    always @(negedge clk) begin
        while (sbq.size() > 0) begin
            exp_t e;
            int af, at, as, ac;
            e  = sbq.pop_front();
            af = (e.sel == 0) ? int'(fb0.flags_q)      : int'(fb1.flags_q);
            at = (e.sel == 0) ? int'(fb0.branch_taken) : int'(fb1.branch_taken);
            as = (e.sel == 0) ? int'(fb0.branch_stall) : int'(fb1.branch_stall);
            ac = (e.sel == 0) ? int'(fb0.stall_count)  : int'(fb1.stall_count);
            if (e.flg >= 0) chk({e.nm, "/flags"}, af, e.flg);
            if (e.tk  >= 0) chk({e.nm, "/taken"}, at, e.tk);
            if (e.st  >= 0) chk({e.nm, "/stall"}, as, e.st);
            if (e.cnt >= 0) chk({e.nm, "/count"}, ac, e.cnt);
        end
    end

    task automatic expb(input string nm, input int flg,
                        input int tk0, input int st0, input int c0,
                        input int tk1, input int st1, input int c1);
        exp_t e;
        e = '{nm: {nm, "#b0"}, sel: 0, flg: flg, tk: tk0, st: st0, cnt: c0};
        sbq.push_back(e);
        e = '{nm: {nm, "#b1"}, sel: 1, flg: flg, tk: tk1, st: st1, cnt: c1};
        sbq.push_back(e);
    endtask

    task automatic drive(input logic v, input logic st, input logic [2:0] op, input logic fs,
                         input logic [2:0] fl, input logic ib, input logic [2:0] ic);
        fb0.ex_valid = v;  fb0.ex_stall = st; fb0.ex_opcode = op; fb0.ex_flags_set = fs;
        fb0.ex_flags = fl; fb0.id_branch = ib; fb0.id_cond = ic;
        fb1.ex_valid = v;  fb1.ex_stall = st; fb1.ex_opcode = op; fb1.ex_flags_set = fs;
        fb1.ex_flags = fl; fb1.id_branch = ib; fb1.id_cond = ic;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] tf[4];
    logic [7:0] tt[4];

    initial begin
        // taken bits indexed by id_cond, worked out by hand per flag value
        tf[0] = 3'b000; tt[0] = 8'b1001_0101;
        tf[1] = 3'b100; tt[1] = 8'b1011_0010;
        tf[2] = 3'b001; tt[2] = 8'b1010_1001;
        tf[3] = 3'b010; tt[3] = 8'b1101_0101;

        rst = 1'b1;
        drive(1, 0, ADD, 1, 3'b111, 0, 3'b000);
        step();
        expb("rst_hold", 0, 0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b0;
        drive(0, 0, ADD, 0, 3'b000, 0, 3'b000);
        expb("rst_rel", 0, 0, 0, 0, 0, 0, 0);
        step();

        drive(1, 0, ADD, 1, 3'b011, 0, 3'b000);       step();
        drive(1, 0, XOR, 1, 3'b100, 0, 3'b000);
        expb("add_load", 3, -1, -1, -1, -1, -1, -1);  step();
        drive(1, 0, PADDSB, 1, 3'b000, 0, 3'b000);
        expb("xor_zonly", 7, -1, -1, -1, -1, -1, -1); step();
        drive(1, 0, SUB, 1, 3'b000, 0, 3'b000);
        expb("paddsb_hold", 7, -1, -1, -1, -1, -1, -1); step();
        drive(1, 0, PADDSB, 1, 3'b111, 0, 3'b000);
        expb("sub_clear", 0, -1, -1, -1, -1, -1, -1); step();
        drive(1, 1, ADD, 1, 3'b101, 0, 3'b000);
        expb("paddsb_zero", 0, -1, -1, -1, -1, -1, -1); step();
        drive(0, 0, ADD, 1, 3'b110, 0, 3'b000);
        expb("exstall_nowr", 0, -1, -1, -1, -1, -1, -1); step();
        drive(0, 0, ADD, 0, 3'b000, 0, 3'b000);
        expb("bubble_nowr", 0, -1, -1, -1, -1, -1, -1); step();

        // flag hazard: SUB sets Z while BEQ sits in ID
        drive(1, 0, SUB, 1, 3'b100, 1, 3'b001);
        expb("hz_c0", 0, 0, 1, 0, 1, 0, 0);           step();
        drive(0, 0, ADD, 0, 3'b000, 1, 3'b001);
        expb("hz_c1", 4, 1, 0, 1, 1, 0, 0);           step();
        drive(0, 0, ADD, 0, 3'b000, 0, 3'b000);
        expb("hz_c2", 4, 0, 0, 1, 0, 0, 0);           step();

        rst = 1'b1;                                    step();
        rst = 1'b0;

        // frozen stall: producer, then three EX-freeze cycles, then release
        drive(1, 0, ADD, 1, 3'b001, 1, 3'b011);
        expb("frz_c0", 0, 0, 1, 0, 1, 0, 0);          step();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, ADD, 0, 3'b000, 1, 3'b011);
            expb($sformatf("frz_w%0d", i), 1, 0, 1, i + 1, 1, 0, 0);
            step();
        end
        drive(0, 0, ADD, 0, 3'b000, 1, 3'b011);
        expb("frz_rel", 1, 1, 0, 4, 1, 0, 0);         step();

        // flush while waiting
        drive(1, 0, SUB, 1, 3'b010, 1, 3'b110);
        expb("fl_c0", 1, 0, 1, 4, 1, 0, 0);           step();
        drive(0, 1, ADD, 0, 3'b000, 0, 3'b110);
        expb("fl_c1", 2, 0, 0, 5, 0, 0, 0);           step();
        drive(0, 0, ADD, 0, 3'b000, 1, 3'b110);
        expb("fl_c2", 2, 1, 0, 5, 1, 0, 0);           step();

        // condition sweep
        for (int fi = 0; fi < 4; fi++) begin
            drive(1, 0, ADD, 1, tf[fi], 0, 3'b000);
            step();
            for (int c = 0; c < 8; c++) begin
                logic [7:0] row;
                row = tt[fi];
                drive(0, 0, ADD, 0, 3'b000, 1, 3'(c));
                expb($sformatf("sw_f%0d_c%0d", tf[fi], c), int'(tf[fi]),
                     int'(row[c]), 0, 5, int'(row[c]), 0, 0);
                step();
            end
        end

        drive(0, 0, ADD, 0, 3'b000, 0, 3'b000);
        @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
